// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO controller with Gray-coded read/write pointers and show-ahead output.
// Optional registered almost_full output enabled by defining GRAY_FIFO_ALMOST_FULL_EN.
module gray_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
`ifdef GRAY_FIFO_ALMOST_FULL_EN
  output logic                  empty,
  output logic                  almost_full
`else
  output logic                  empty
`endif
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0]         wr_bin_q, wr_bin_d;
  logic [PW-1:0]         rd_bin_q, rd_bin_d;
  logic [PW-1:0]         wr_gray_q, wr_gray_d;
  logic [PW-1:0]         rd_gray_q, rd_gray_d;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  full_s;
  logic                  empty_s;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Flag decode from the registered Gray pointers; full means the MSB pair differs, rest equal.
  always_comb begin
    empty_s = (wr_gray_q == rd_gray_q);
    full_s  = (wr_gray_q == {~rd_gray_q[ADDR_WIDTH:ADDR_WIDTH-1], rd_gray_q[ADDR_WIDTH-2:0]});
  end

  // Handshake acceptance and next-state pointer arithmetic.
  always_comb begin
    wr_bin_d  = wr_bin_q;
    rd_bin_d  = rd_bin_q;
    wr_en_s   = din_valid & ~full_s;
    rd_en_s   = dout_ready & ~empty_s;
    if (wr_en_s) begin
      wr_bin_d = wr_bin_q + PW'(1);
    end else begin
      wr_bin_d = wr_bin_q;
    end
    if (rd_en_s) begin
      rd_bin_d = rd_bin_q + PW'(1);
    end else begin
      rd_bin_d = rd_bin_q;
    end
    wr_gray_d = bin2gray(wr_bin_d);
    rd_gray_d = bin2gray(rd_bin_d);
  end

  // Pointer registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bin_q  <= {PW{1'b0}};
      rd_bin_q  <= {PW{1'b0}};
      wr_gray_q <= {PW{1'b0}};
      rd_gray_q <= {PW{1'b0}};
    end else begin
      wr_bin_q  <= wr_bin_d;
      rd_bin_q  <= rd_bin_d;
      wr_gray_q <= wr_gray_d;
      rd_gray_q <= rd_gray_d;
    end
  end

  // Storage array; contents survive reset and are masked by empty.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_bin_q[ADDR_WIDTH-1:0]] <= din;
    end
  end

`ifdef GRAY_FIFO_ALMOST_FULL_EN
  logic [PW-1:0] count_d;
  logic          almost_full_q, almost_full_d;

  // Threshold on next occupancy so the flag tracks count after each edge.
  always_comb begin
    count_d       = wr_bin_d - rd_bin_d;
    almost_full_d = (count_d >= PW'(AF_THRESH));
  end

  // Almost-full register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end

  assign almost_full = almost_full_q;
`endif

  assign wr_ptr_gray = wr_gray_q;
  assign rd_ptr_gray = rd_gray_q;
  assign count       = wr_bin_q - rd_bin_q;
  assign full        = full_s;
  assign empty       = empty_s;
  assign din_ready   = ~full_s;
  assign dout_valid  = ~empty_s;
  assign dout        = mem_q[rd_bin_q[ADDR_WIDTH-1:0]];

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Scoreboard bench for gray_fifo_ctrl: queued expected words, reference pointer model.
// Exercises almost_full too when GRAY_FIFO_ALMOST_FULL_EN is defined.
module tb_gray_fifo_ctrl;
  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [3:0] wr_ptr_gray;
  logic [3:0] rd_ptr_gray;
  logic [3:0] count;
  logic       full;
  logic       empty;
`ifdef GRAY_FIFO_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int checks   = 0;
  int failures = 0;

  logic [3:0] wr_m, rd_m;
  logic [7:0] sb[$];

  gray_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_THRESH(6)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray), .count(count),
`ifdef GRAY_FIFO_ALMOST_FULL_EN
    .full(full), .empty(empty), .almost_full(almost_full)
`else
    .full(full), .empty(empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // One clock of traffic; accepted reads pop the scoreboard and compare the show-ahead word.
  task automatic step(input logic wv, input logic [7:0] wd, input logic rr);
    logic [3:0] cnt_m;
    logic       w_acc, r_acc;
    logic [7:0] exp_d;
    cnt_m = wr_m - rd_m;
    w_acc = wv && (cnt_m != 4'd8);
    r_acc = rr && (cnt_m != 4'd0);
    din = wd; din_valid = wv; dout_ready = rr;
    #1;
    if (r_acc) begin
      exp_d = sb.pop_front();
      checks++;
      if (dout !== exp_d) begin
        failures++;
        $display("FAIL dout_pop got=%h exp=%h", dout, exp_d);
      end
    end
    if (w_acc) sb.push_back(wd);
    @(posedge clk);
    #1;
    if (w_acc) wr_m = wr_m + 4'd1;
    if (r_acc) rd_m = rd_m + 4'd1;
    din_valid = 1'b0; dout_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    wr_m = 4'd0; rd_m = 4'd0;
    sb.delete();
  endtask

  task automatic test_reset();
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({empty, full, count, wr_ptr_gray, rd_ptr_gray, din_ready, dout_valid} !== {1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_async got e=%b f=%b c=%0d wg=%b rg=%b dr=%b dv=%b exp e=1 f=0 c=0 wg=0000 rg=0000 dr=1 dv=0",
               empty, full, count, wr_ptr_gray, rd_ptr_gray, din_ready, dout_valid);
    end
    #2;
    reset = 1'b0;
    wr_m = 4'd0; rd_m = 4'd0;
    sb.delete();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    checks++;
    if ({wr_ptr_gray, count, full, din_ready, empty} !== {4'b1100, 4'd8, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL fill_full got wg=%b c=%0d f=%b dr=%b e=%b exp wg=1100 c=8 f=1 dr=0 e=0",
               wr_ptr_gray, count, full, din_ready, empty);
    end
    step(1'b1, 8'hFF, 1'b0);
    checks++;
    if ({count, wr_ptr_gray} !== {4'd8, 4'b1100}) begin
      failures++;
      $display("FAIL fill_overflow got c=%0d wg=%b exp c=8 wg=1100", count, wr_ptr_gray);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    checks++;
    if ({rd_ptr_gray, empty, count, dout_valid} !== {4'b1100, 1'b1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL drain_empty got rg=%b e=%b c=%0d dv=%b exp rg=1100 e=1 c=0 dv=0",
               rd_ptr_gray, empty, count, dout_valid);
    end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if ({rd_ptr_gray, count} !== {4'b1100, 4'd0}) begin
      failures++;
      $display("FAIL drain_underflow got rg=%b c=%0d exp rg=1100 c=0", rd_ptr_gray, count);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] pw, pr;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      pw = wr_ptr_gray;
      step(1'b1, 8'(8'h80 + i), 1'b0);
      checks++;
      if ($countones(pw ^ wr_ptr_gray) != 1 || wr_ptr_gray !== g(wr_m)) begin
        failures++;
        $display("FAIL wrap_wr_gray step=%0d got=%b prev=%b exp=%b", i, wr_ptr_gray, pw, g(wr_m));
      end
      pr = rd_ptr_gray;
      step(1'b0, 8'h00, 1'b1);
      checks++;
      if ($countones(pr ^ rd_ptr_gray) != 1 || rd_ptr_gray !== g(rd_m)) begin
        failures++;
        $display("FAIL wrap_rd_gray step=%0d got=%b prev=%b exp=%b", i, rd_ptr_gray, pr, g(rd_m));
      end
    end
    checks++;
    if ({wr_ptr_gray, rd_ptr_gray, empty} !== {4'b0000, 4'b0000, 1'b1}) begin
      failures++;
      $display("FAIL wrap_final got wg=%b rg=%b e=%b exp wg=0000 rg=0000 e=1", wr_ptr_gray, rd_ptr_gray, empty);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
    step(1'b1, 8'h23, 1'b1);
    checks++;
    if ({count, wr_ptr_gray, rd_ptr_gray} !== {4'd3, g(4'd4), g(4'd1)}) begin
      failures++;
      $display("FAIL simul_mid got c=%0d wg=%b rg=%b exp c=3 wg=%b rg=%b", count, wr_ptr_gray, rd_ptr_gray, g(4'd4), g(4'd1));
    end
    for (int i = 0; i < 5; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    checks++;
    if ({count, din_ready} !== {4'd7, 1'b1}) begin
      failures++;
      $display("FAIL simul_full got c=%0d dr=%b exp c=7 dr=1", count, din_ready);
    end
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    checks++;
    if ({count, dout_valid, dout} !== {4'd1, 1'b1, 8'h5A}) begin
      failures++;
      $display("FAIL simul_empty got c=%0d dv=%b d=%h exp c=1 dv=1 d=5a", count, dout_valid, dout);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
    checks++;
    if (count !== 4'd5) begin
      failures++;
      $display("FAIL midrst_pre got c=%0d exp c=5", count);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({empty, full, count, wr_ptr_gray, rd_ptr_gray, din_ready, dout_valid} !== {1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL midrst_async got e=%b f=%b c=%0d wg=%b rg=%b dr=%b dv=%b exp e=1 f=0 c=0 wg=0000 rg=0000 dr=1 dv=0",
               empty, full, count, wr_ptr_gray, rd_ptr_gray, din_ready, dout_valid);
    end
    #1;
    reset = 1'b0;
    wr_m = 4'd0; rd_m = 4'd0;
    sb.delete();
    step(1'b1, 8'hA5, 1'b0);
    checks++;
    if ({dout_valid, dout, count} !== {1'b1, 8'hA5, 4'd1}) begin
      failures++;
      $display("FAIL midrst_post got dv=%b d=%h c=%0d exp dv=1 d=a5 c=1", dout_valid, dout, count);
    end
  endtask

`ifdef GRAY_FIFO_ALMOST_FULL_EN
  task automatic test_almost_full();
    apply_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h70 + 8'(i), 1'b0);
    checks++;
    if (almost_full !== 1'b0) begin
      failures++;
      $display("FAIL af_at5 got=%b exp=0", almost_full);
    end
    step(1'b1, 8'h75, 1'b0);
    checks++;
    if (almost_full !== 1'b1) begin
      failures++;
      $display("FAIL af_at6 got=%b exp=1", almost_full);
    end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (almost_full !== 1'b0) begin
      failures++;
      $display("FAIL af_drop5 got=%b exp=0", almost_full);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; din = 8'h00; din_valid = 1'b0; dout_ready = 1'b0;
    wr_m = 4'd0; rd_m = 4'd0;
    #12;
    reset = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
`ifdef GRAY_FIFO_ALMOST_FULL_EN
    test_almost_full();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gray_fifo_ctrl.md
Name: gray_fifo_ctrl

Overview:
- Single-clock FIFO that sequences two Gray-coded pointers: one write pointer and one read pointer, each ADDR_WIDTH+1 bits.
- Each pointer is kept as a binary counter; its Gray value is binary ^ (binary >> 1).
- Full and empty are derived from the Gray pointers, which are exported for downstream CDC/debug consumers.
- Owns a 2^ADDR_WIDTH-entry storage array and provides valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 3, log2 of FIFO depth (DEPTH = 2^ADDR_WIDTH = 8).
- AF_THRESH, 6, almost-full threshold in entries; used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  write data.
- din_valid  input  1  producer has a word.
- din_ready  output  1  FIFO can accept a word; equals ~full.
- dout  output  DATA_WIDTH  head-of-FIFO word (show-ahead).
- dout_valid  output  1  head word valid; equals ~empty.
- dout_ready  input  1  consumer takes the head word.
- wr_ptr_gray  output  ADDR_WIDTH+1  Gray-coded write pointer.
- rd_ptr_gray  output  ADDR_WIDTH+1  Gray-coded read pointer.
- count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.

Behaviour:
- Reset (async assert; deassert synchronous to clk):
  - binary write/read pointers = 0, so wr_ptr_gray = rd_ptr_gray = 0.
  - empty = 1, full = 0, count = 0, din_ready = 1, dout_valid = 0.
  - Storage is not reset. dout is don't-care while empty.
- Write: on a clk edge with din_valid & din_ready:
  - mem[wr_bin[ADDR_WIDTH-1:0]] <= din.
  - wr_bin <= wr_bin + 1, wrapping modulo 2^(ADDR_WIDTH+1).
- Read: on a clk edge with dout_valid & dout_ready, rd_bin <= rd_bin + 1 with the same wrap.
- dout is combinational from mem[rd_bin[ADDR_WIDTH-1:0]].
- Latency: a word written at edge N is visible on dout with dout_valid = 1 after edge N (first word into an empty FIFO).
- Gray outputs are registered: wr_ptr_gray = wr_bin ^ (wr_bin >> 1), same form for rd_ptr_gray.
  - Exactly one bit of each changes per increment, including the wrap from 2^(ADDR_WIDTH+1)-1 to 0.
- empty = (wr_ptr_gray == rd_ptr_gray).
- full = (wr_ptr_gray == {~rd_ptr_gray[ADDR_WIDTH:ADDR_WIDTH-1], rd_ptr_gray[ADDR_WIDTH-2:0]}), i.e. top two bits inverted, rest equal.
  - full and empty are never both 1.
- count = wr_bin - rd_bin, modulo 2^(ADDR_WIDTH+1).
- Simultaneous read and write while neither full nor empty: both pointers advance and count is unchanged.
- When full:
  - din_ready = 0, so a write is blocked even if a read occurs in the same cycle.
  - din_ready has no combinational path from dout_ready.
- When empty: a read is not accepted; a write in the same cycle is accepted.
- din_valid while full and dout_ready while empty are ignored; no state changes.
- Reset mid-operation: all contents are discarded immediately and outputs return to reset values asynchronously.
- Handshake stability: din and din_valid may change freely. The FIFO has no obligation beyond sampling on clk edges.

Optional Feature:
- Macro: GRAY_FIFO_ALMOST_FULL_EN.
- Defined:
  - Adds output almost_full, 1 bit, registered; equals (count >= AF_THRESH) after each edge.
  - Reset value 0.
  - Example: with AF_THRESH = 6, asserts once count reaches 6 and deasserts when count drops to 5.
- Not defined: the port is absent and AF_THRESH is unused. All other behaviour is identical.

Test Plan (DATA_WIDTH = 8, ADDR_WIDTH = 3):
- Reset: assert reset mid-clock with no clk edge -> immediately empty = 1, full = 0, count = 0, wr_ptr_gray = rd_ptr_gray = 4'b0000, din_ready = 1, dout_valid = 0.
- Fill to full: write 0x10..0x17 on 8 consecutive edges with dout_ready = 0 -> wr_ptr_gray = 4'b1100, count = 8, full = 1, din_ready = 0. A 9th write of 0xFF is ignored, count stays 8.
- Drain: dout_ready = 1 for 8 edges -> dout sequence 0x10..0x17 in order, rd_ptr_gray = 4'b1100, empty = 1, count = 0. Further dout_ready has no effect.
- Wrap: 16 writes interleaved with 16 reads -> both Gray pointers return to 4'b0000. A checker confirms exactly one Gray bit toggles per increment, including 4'b1000 -> 4'b0000.
- Simultaneous traffic:
  - At count = 3, write and read on the same edge -> count stays 3, both pointers advance by one.
  - At full, write plus read -> only the read is accepted, count = 7.
  - At empty, write plus read -> only the write is accepted, count = 1.
- Reset mid-operation: at count = 5, assert reset -> outputs return to reset values asynchronously. After release, write 0xA5 -> dout = 0xA5 and dout_valid = 1 after that edge.
- With GRAY_FIFO_ALMOST_FULL_EN, AF_THRESH = 6: almost_full rises after the 6th write and falls after the read that brings count to 5.
